// File: rtl/bf_relax_engine_if.sv
// Memory-side bundle of the Bellman-Ford relaxation engine: the three ports
// of the 2R1W working memory (one write port, two asynchronous read ports).
//   master : driven by the engine (write enable/address/data, read addresses),
//            receives ReadBus1/ReadBus2.
//   slave  : the memory side, returns read data for the presented addresses.
interface bf_relax_engine_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 128
);
  logic              WE;
  logic [ADDR_W-1:0] WriteAddress;
  logic [DATA_W-1:0] WriteBus;
  logic [ADDR_W-1:0] ReadAddress1;
  logic [ADDR_W-1:0] ReadAddress2;
  logic [DATA_W-1:0] ReadBus1;
  logic [DATA_W-1:0] ReadBus2;

  modport master (
    output WE, WriteAddress, WriteBus, ReadAddress1, ReadAddress2,
    input  ReadBus1, ReadBus2
  );

  modport slave (
    input  WE, WriteAddress, WriteBus, ReadAddress1, ReadAddress2,
    output ReadBus1, ReadBus2
  );
endinterface

// File: rtl/bf_relax_engine.sv
// Bellman-Ford relaxation engine. Initialises a distance table in the working
// memory, then sweeps the edge list pass by pass, relaxing each edge through
// the two read ports and writing improved distances back. Stops early when a
// pass changes nothing; otherwise runs one extra check pass after
// num_nodes-1 passes and flags a negative cycle if anything still relaxes.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 1-cycle run request, sampled only when idle
//   num_nodes, num_edges  problem size (latched at start)
//   edge_base, dist_base  word addresses of edge 0 / node 0 distance word
//   source                source node index
//   busy, done            run in progress / 1-cycle end-of-run pulse
//   neg_cycle             negative cycle found (held until next start)
//   iterations            completed normal passes (held until next start)
//   mem                   memory bundle (write port + two read ports)
//
// Word formats:
//   edge     : [12:0] src, [25:13] dst, [57:26] signed weight
//   distance : [31:0] signed distance, [44:32] predecessor, rest zero
module bf_relax_engine #(
  parameter int                ADDR_W  = 13,
  parameter int                DATA_W  = 128,
  parameter logic signed [31:0] INF    = 32'sh7FFF_FFFF,
  parameter logic [ADDR_W-1:0] NO_PRED = {ADDR_W{1'b1}}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_nodes,
  input  logic [ADDR_W-1:0] num_edges,
  input  logic [ADDR_W-1:0] edge_base,
  input  logic [ADDR_W-1:0] dist_base,
  input  logic [ADDR_W-1:0] source,
  output logic              busy,
  output logic              done,
  output logic              neg_cycle,
  output logic [ADDR_W-1:0] iterations,
  bf_relax_engine_if.master mem
);

  localparam int PAY_W = 32 + ADDR_W;
  localparam int W_LO  = 2 * ADDR_W;
  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic signed [32:0] CAND_MAX = $signed({INF[31], INF}) - 33'sd1;
  localparam logic signed [32:0] CAND_MIN = $signed({1'b1, 32'h8000_0000});

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_EDGE_RD, S_DIST_RD, S_EVAL, S_WRITE, S_NEXT, S_DONE
  } state_t;

  // Clamp the 33-bit sum into [-2^31, INF-1] so a relaxed distance can never
  // alias the "unreached" marker or wrap around.
  function automatic logic signed [31:0] sat_dist(input logic signed [32:0] s);
    logic signed [32:0] c;
    if (s > CAND_MAX)      c = CAND_MAX;
    else if (s < CAND_MIN) c = CAND_MIN;
    else                   c = s;
    return c[31:0];
  endfunction

  function automatic logic [DATA_W-1:0] dist_word(input logic signed [31:0] d,
                                                  input logic [ADDR_W-1:0]  p);
    return {{(DATA_W-PAY_W){1'b0}}, p, d};
  endfunction

  state_t              state;
  logic                we;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [ADDR_W-1:0]   rd_addr1;
  logic [ADDR_W-1:0]   rd_addr2;
  logic                check_pass;
  logic                pass_changed;
  logic [ADDR_W-1:0]   idx;          // node index in INIT, edge index otherwise

  logic [ADDR_W-1:0]   cfg_nodes, cfg_edges, cfg_edge_base, cfg_dist_base, cfg_source;
  logic [ADDR_W-1:0]   e_src, e_dst;
  logic signed [31:0]  e_w;
  logic signed [31:0]  d_src, d_dst;

  logic [ADDR_W-1:0]   idx_next, iter_next, nodes_m1, edges_m1;
  logic [ADDR_W-1:0]   f_src, f_dst;
  logic signed [31:0]  f_w;
  logic signed [32:0]  sum;
  logic signed [31:0]  cand;
  logic                relax;
  logic                unused_bits;

  assign idx_next  = idx + ONE;
  assign iter_next = iterations + ONE;
  assign nodes_m1  = cfg_nodes - ONE;
  assign edges_m1  = cfg_edges - ONE;

  assign f_src = mem.ReadBus1[ADDR_W-1:0];
  assign f_dst = mem.ReadBus1[W_LO-1:ADDR_W];
  assign f_w   = $signed(mem.ReadBus1[W_LO+31:W_LO]);

  assign sum   = $signed({d_src[31], d_src}) + $signed({e_w[31], e_w});
  assign cand  = sat_dist(sum);
  assign relax = (d_src != INF) && (cand < d_dst);

  assign unused_bits = ^{mem.ReadBus1[DATA_W-1:W_LO+32], mem.ReadBus2[DATA_W-1:32]};

  assign mem.WE           = we;
  assign mem.WriteAddress = wr_addr;
  assign mem.WriteBus     = wr_data;
  assign mem.ReadAddress1 = rd_addr1;
  assign mem.ReadAddress2 = rd_addr2;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      neg_cycle    <= 1'b0;
      iterations   <= '0;
      we           <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      rd_addr1     <= '0;
      rd_addr2     <= '0;
      check_pass   <= 1'b0;
      pass_changed <= 1'b0;
      idx          <= '0;
    end else begin
      done <= 1'b0;
      we   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cfg_nodes     <= num_nodes;
            cfg_edges     <= num_edges;
            cfg_edge_base <= edge_base;
            cfg_dist_base <= dist_base;
            cfg_source    <= source;
            neg_cycle     <= 1'b0;
            iterations    <= '0;
            check_pass    <= 1'b0;
            pass_changed  <= 1'b0;
            idx           <= '0;
            busy          <= 1'b1;
            if (num_nodes == '0) begin
              state <= S_DONE;
            end else begin
              // Node 0 is written during the first INIT cycle.
              we      <= 1'b1;
              wr_addr <= dist_base;
              wr_data <= dist_word((source == '0) ? 32'sd0 : INF, NO_PRED);
              state   <= S_INIT;
            end
          end
        end

        S_INIT: begin
          if (idx == nodes_m1) begin
            if (cfg_edges == '0) begin
              state <= S_DONE;
            end else begin
              idx      <= '0;
              rd_addr1 <= cfg_edge_base;
              state    <= S_EDGE_RD;
            end
          end else begin
            we      <= 1'b1;
            wr_addr <= cfg_dist_base + idx_next;
            wr_data <= dist_word((idx_next == cfg_source) ? 32'sd0 : INF, NO_PRED);
            idx     <= idx_next;
          end
        end

        // Edge word is on ReadBus1; aim both read ports at its endpoints.
        S_EDGE_RD: begin
          e_src    <= f_src;
          e_dst    <= f_dst;
          e_w      <= f_w;
          rd_addr1 <= cfg_dist_base + f_src;
          rd_addr2 <= cfg_dist_base + f_dst;
          state    <= S_DIST_RD;
        end

        S_DIST_RD: begin
          d_src <= $signed(mem.ReadBus1[31:0]);
          d_dst <= $signed(mem.ReadBus2[31:0]);
          state <= S_EVAL;
        end

        S_EVAL: begin
          if (relax && check_pass) begin
            neg_cycle <= 1'b1;
            state     <= S_DONE;
          end else if (relax) begin
            we      <= 1'b1;
            wr_addr <= cfg_dist_base + e_dst;
            wr_data <= dist_word(cand, e_src);
            state   <= S_WRITE;
          end else begin
            state <= S_NEXT;
          end
        end

        S_WRITE: begin
          pass_changed <= 1'b1;
          state        <= S_NEXT;
        end

        S_NEXT: begin
          if (idx < edges_m1) begin
            idx      <= idx_next;
            rd_addr1 <= cfg_edge_base + idx_next;
            state    <= S_EDGE_RD;
          end else begin
            if (!check_pass) iterations <= iter_next;
            if (check_pass || !pass_changed) begin
              state <= S_DONE;
            end else begin
              // After num_nodes-1 changing passes, the next pass only checks.
              check_pass   <= (iter_next >= nodes_m1);
              pass_changed <= 1'b0;
              idx          <= '0;
              rd_addr1     <= cfg_edge_base;
              state        <= S_EDGE_RD;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_relax_engine.sv
// Directed bench for bf_relax_engine with a behavioural 8K x 128 2R1W memory.
module tb_bf_relax_engine;
  localparam logic [31:0] INF = 32'h7FFF_FFFF;
  localparam logic [12:0] NP  = 13'h1FFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [12:0] num_nodes = '0, num_edges = '0, edge_base = '0, dist_base = '0, source = '0;
  logic        busy, done, neg_cycle;
  logic [12:0] iterations;

  bf_relax_engine_if #(.ADDR_W(13), .DATA_W(128)) ifc ();

  bf_relax_engine dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .num_nodes  (num_nodes),
    .num_edges  (num_edges),
    .edge_base  (edge_base),
    .dist_base  (dist_base),
    .source     (source),
    .busy       (busy),
    .done       (done),
    .neg_cycle  (neg_cycle),
    .iterations (iterations),
    .mem        (ifc)
  );

  always #5 clock = ~clock;

  // Memory model: asynchronous reads, write committed on the rising edge.
  logic [127:0] memory [0:8191];
  logic         tb_we   = 1'b0;
  logic [12:0]  tb_addr = '0;
  logic [127:0] tb_data = '0;
  int           wr_count = 0;
  logic [12:0]  wr_log [0:255];

  assign ifc.ReadBus1 = memory[ifc.ReadAddress1];
  assign ifc.ReadBus2 = memory[ifc.ReadAddress2];

  always @(posedge clock) begin
    if (ifc.WE) begin
      memory[ifc.WriteAddress] <= ifc.WriteBus;
      wr_log[wr_count % 256]   <= ifc.WriteAddress;
      wr_count                 <= wr_count + 1;
    end else if (tb_we) begin
      memory[tb_addr] <= tb_data;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_edge(input int s, input int d, input logic [31:0] w);
    return {70'b0, w, 13'(d), 13'(s)};
  endfunction

  function automatic logic [127:0] dw(input logic [31:0] d, input logic [12:0] p);
    return {83'b0, p, d};
  endfunction

  task automatic pl(input int a, input logic [127:0] d);
    tb_we = 1'b1; tb_addr = 13'(a); tb_data = d;
    @(posedge clock); #1;
    tb_we = 1'b0;
  endtask

  task automatic run_cfg(input int nn, input int ne, input int eb, input int db, input int src);
    @(posedge clock); #1;
    num_nodes = 13'(nn); num_edges = 13'(ne);
    edge_base = 13'(eb); dist_base = 13'(db); source = 13'(src);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Waits for done; busy cycles and latency (cycles since start was raised).
  task automatic wait_done(input int maxc, output int bc, output int lat, output bit got);
    bc = 0; lat = 0; got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (done) begin got = 1'b1; lat = i + 1; break; end
      if (busy) bc++;
      @(posedge clock); #1;
    end
  endtask

  int bc, lat, base;
  bit got, found;

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy",  128'(busy), 128'(0));
    chk("rst_done",  128'(done), 128'(0));
    chk("rst_neg",   128'(neg_cycle), 128'(0));
    chk("rst_iter",  128'(iterations), 128'(0));
    chk("rst_we",    128'(ifc.WE), 128'(0));
    chk("rst_waddr", 128'(ifc.WriteAddress), 128'(0));
    chk("rst_wbus",  ifc.WriteBus, 128'(0));
    chk("rst_ra1",   128'(ifc.ReadAddress1), 128'(0));
    chk("rst_ra2",   128'(ifc.ReadAddress2), 128'(0));
    reset = 1'b0;

    // Shortest paths
    pl(0, mk_edge(0, 1, 5));
    pl(1, mk_edge(1, 2, -2));
    pl(2, mk_edge(0, 2, 4));
    base = wr_count;
    run_cfg(3, 3, 0, 100, 0);
    wait_done(200, bc, lat, got);
    chk("sp_done", 128'(got), 128'(1));
    chk("sp_busy_cycles", 128'(bc), 128'(30));
    chk("sp_iter", 128'(iterations), 128'(2));
    chk("sp_neg", 128'(neg_cycle), 128'(0));
    chk("sp_d0", memory[100], dw(32'd0, NP));
    chk("sp_d1", memory[101], dw(32'd5, 13'd0));
    chk("sp_d2", memory[102], dw(32'd3, 13'd1));
    chk("sp_writes", 128'(wr_count - base), 128'(5));
    @(posedge clock); #1;
    chk("sp_done_pulse", 128'(done), 128'(0));
    chk("sp_busy_low", 128'(busy), 128'(0));

    // Negative cycle
    pl(50, mk_edge(0, 1, 1));
    pl(51, mk_edge(1, 0, -3));
    base = wr_count;
    run_cfg(2, 2, 50, 300, 0);
    wait_done(200, bc, lat, got);
    chk("neg_done", 128'(got), 128'(1));
    chk("neg_flag", 128'(neg_cycle), 128'(1));
    chk("neg_iter", 128'(iterations), 128'(1));
    chk("neg_busy_cycles", 128'(bc), 128'(16));
    chk("neg_d0", memory[300], dw(32'hFFFF_FFFE, 13'd1));
    chk("neg_writes", 128'(wr_count - base), 128'(4));

    // Zero nodes
    base = wr_count;
    run_cfg(0, 5, 0, 900, 0);
    wait_done(20, bc, lat, got);
    chk("n0_done", 128'(got), 128'(1));
    chk("n0_latency", 128'(lat), 128'(2));
    chk("n0_writes", 128'(wr_count - base), 128'(0));
    chk("n0_neg_cleared", 128'(neg_cycle), 128'(0));
    chk("n0_iter", 128'(iterations), 128'(0));

    // Zero edges
    base = wr_count;
    run_cfg(4, 0, 0, 400, 2);
    wait_done(50, bc, lat, got);
    chk("e0_done", 128'(got), 128'(1));
    chk("e0_writes", 128'(wr_count - base), 128'(4));
    chk("e0_d0", memory[400], dw(INF, NP));
    chk("e0_d1", memory[401], dw(INF, NP));
    chk("e0_d2", memory[402], dw(32'd0, NP));
    chk("e0_d3", memory[403], dw(INF, NP));
    chk("e0_iter", 128'(iterations), 128'(0));

    // Address wrap and saturation
    pl(200, mk_edge(0, 1, -1));
    pl(201, mk_edge(1, 2, 32'h8000_0000));
    base = wr_count;
    run_cfg(3, 2, 200, 8190, 0);
    wait_done(200, bc, lat, got);
    chk("wr_done", 128'(got), 128'(1));
    chk("wr_addr0", 128'(wr_log[base % 256]), 128'(8190));
    chk("wr_addr1", 128'(wr_log[(base + 1) % 256]), 128'(8191));
    chk("wr_addr2", 128'(wr_log[(base + 2) % 256]), 128'(0));
    chk("wr_d0", memory[8190], dw(32'd0, NP));
    chk("wr_d1", memory[8191], dw(32'hFFFF_FFFF, 13'd0));
    chk("sat_d2", memory[0], dw(32'h8000_0000, 13'd1));
    chk("wr_iter", 128'(iterations), 128'(2));
    chk("wr_writes", 128'(wr_count - base), 128'(5));

    // Start while busy, with configuration changed mid-run
    pl(0, mk_edge(0, 1, 5));
    pl(1, mk_edge(1, 2, -2));
    pl(2, mk_edge(0, 2, 4));
    base = wr_count;
    run_cfg(3, 3, 0, 600, 0);
    repeat (6) @(posedge clock);
    #1;
    num_nodes = 13'd2; num_edges = 13'd1; dist_base = 13'd900; source = 13'd1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("ign_busy", 128'(busy), 128'(1));
    wait_done(200, bc, lat, got);
    chk("ign_done", 128'(got), 128'(1));
    chk("ign_iter", 128'(iterations), 128'(2));
    chk("ign_writes", 128'(wr_count - base), 128'(5));
    chk("ign_d2", memory[602], dw(32'd3, 13'd1));

    // Reset during a relax write
    base = wr_count;
    run_cfg(3, 3, 0, 700, 0);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ifc.WE && (wr_count - base) == 3) begin found = 1'b1; break; end
      @(posedge clock); #1;
    end
    chk("rw_found", 128'(found), 128'(1));
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rw_we", 128'(ifc.WE), 128'(0));
    chk("rw_busy", 128'(busy), 128'(0));
    chk("rw_writes", 128'(wr_count - base), 128'(4));
    reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("rw_writes_after", 128'(wr_count - base), 128'(4));
    chk("rw_busy_after", 128'(busy), 128'(0));
    chk("rw_d2_untouched", memory[702], dw(INF, NP));

    // Unreachable node
    pl(20, mk_edge(0, 1, 2));
    pl(21, mk_edge(2, 1, -5));
    pl(22, mk_edge(2, 0, 1));
    base = wr_count;
    run_cfg(3, 3, 20, 800, 0);
    wait_done(200, bc, lat, got);
    chk("ur_done", 128'(got), 128'(1));
    chk("ur_d0", memory[800], dw(32'd0, NP));
    chk("ur_d1", memory[801], dw(32'd2, 13'd0));
    chk("ur_d2", memory[802], dw(INF, NP));
    chk("ur_writes", 128'(wr_count - base), 128'(4));
    chk("ur_iter", 128'(iterations), 128'(2));
    chk("ur_neg", 128'(neg_cycle), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
